uart_rx_deserializer: RTL
=========================

Name: uart_rx_deserializer

Overview:
Serial-to-parallel UART receiver core; the stage directly downstream of the UART transmitter on the serial line (tx → rx, loopback or link partner).
Oversamples the asynchronous rx line, frames start/data/parity/stop bits and emits one byte per frame with error flags.
Frame configuration inputs match the transmitter's encoding, so one config register drives both sides.
Sits below the future AXI-lite receiver IP, which pushes its output into an rx FIFO.

Parameters:
OVERSAMPLE, 16, sample ticks per bit; even, ≥4
DIV_WIDTH, 16, width of clk_div

Ports:
clk  in  1  system clock (AXI clock domain)
rst  in  1  synchronous, active-high reset
rx  in  1  asynchronous serial input, idle high
clk_div  in  DIV_WIDTH  clocks per oversample tick minus 1
data_size  in  1  0: 7-bit, 1: 8-bit
parity_en  in  1  parity bit present
parity_mode  in  2  11 odd, 10 even, 01 mark(1), 00 space(0)
stop_bit_size  in  1  0: 1 stop bit, 1: 2 stop bits
data  out  8  received byte; bit7=0 in 7-bit mode
valid  out  1  one-cycle pulse, new byte on data
parity_error  out  1  parity mismatch for the byte on data
frame_error  out  1  a stop bit sampled 0 for the byte on data
busy  out  1  high in any state except IDLE

Behaviour:
- One clock, reset synchronous active-high; all state advances on posedge clk.
- Reset values: data=0, valid=0, parity_error=0, frame_error=0, busy=0, state=IDLE, counters=0, armed=0.
- rx passes a 2-FF synchronizer (rx_s) always; all decisions use rx_s; add 2 clocks of input latency.
- Tick generator: counter 0..clk_div_l, tick when count==clk_div_l, then wraps to 0; held at 0 in IDLE. clk_div=0 means tick every clock.
- Config latch: clk_div, data_size, parity_en, parity_mode, stop_bit_size are latched on IDLE→START. Mid-frame input changes take effect next frame.
- armed: set when rx_s==1 in IDLE; cleared on leaving IDLE. A start requires armed, so a line held low after a break is not re-triggered.
- States:
  - IDLE: armed & rx_s==0 → START; clear tick and sample counters.
  - START: after OVERSAMPLE/2 ticks (mid start bit), sample. 1 → IDLE (glitch, no output). 0 → DATA, clear bit counter.
  - DATA: sample every OVERSAMPLE ticks, LSB first. After 7 (data_size=0) or 8 bits → PARITY if parity_en, else STOP1.
  - PARITY: sample after OVERSAMPLE ticks. Expected bit: odd = ~^bits, even = ^bits, mark = 1, space = 0, over the received 7 or 8 bits.
  - STOP1: sample after OVERSAMPLE ticks; 0 sets the frame error. stop_bit_size=1 → STOP2, else finish.
  - STOP2: same check as STOP1, then finish.
- Finish is taken at the mid-stop sample, so a following start edge is never missed:
  - next clock: valid=1 for exactly one cycle; data, parity_error and frame_error update together;
  - state → IDLE.
- data and error flags hold until the next valid; they are not cleared by a glitch abort.
- Reset mid-frame: immediate return to IDLE with reset values; no valid for the partial frame.

Optional Feature:
UART_RX_MAJORITY_VOTE_EN
- Defined: each bit value (start check included) is the majority of rx_s on three consecutive ticks ending at the sample tick. A single-tick glitch at the sample point is rejected.
- Undefined: single rx_s sample at the sample tick.
- Frame timing and valid latency are identical in both builds.

Test Plan:
- 8N1: clk_div=3, tx 0xA5 at 64 clocks/bit → exactly one valid, data=0xA5, parity_error=0, frame_error=0, busy low after valid.
- 7E1: data_size=0, parity_en=1, parity_mode=10, tx 0x41 with parity 0 → data=0x41, parity_error=0. Repeat with parity bit inverted → parity_error=1, data=0x41.
- Frame error/break: 8N1 0x00 with stop bit forced 0, then rx held low 1000 clocks → one valid, frame_error=1; no further valid until rx returns high and a new start arrives.
- Glitch: rx low for 20 clocks (< 32-clock half bit, clk_div=3) → no valid, busy returns 0, data unchanged.
- Reset mid-DATA: rst pulse during bit 3 of 0x3C → all outputs 0. Next frame 0x5A is received correctly with errors 0.
- Back-to-back 8N2, parity odd: 0x00 then 0xFF with no idle gap → two valids, data 0x00 then 0xFF, no errors. With the macro defined, a 1-tick low glitch at the mid-point of a data '1' bit still yields 0xFF.

Source files
------------

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: oversampling UART receiver core.
// Synchronizes rx, frames start/data/parity/stop bits and emits one byte per
// frame with parity and framing error flags.
// Optional build macro UART_RX_MAJORITY_VOTE_EN: each bit decision is the
// majority of three consecutive tick samples instead of a single sample.
module uart_rx_deserializer #(
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic [DIV_WIDTH-1:0] clk_div,
  input  logic                 data_size,
  input  logic                 parity_en,
  input  logic [1:0]           parity_mode,
  input  logic                 stop_bit_size,
  output logic [7:0]           data,
  output logic                 valid,
  output logic                 parity_error,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] HALF_M1 = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] FULL_M1 = SW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  state_t               state;
  logic                 rx_m, rx_s;
  logic                 armed;
  logic [DIV_WIDTH-1:0] tick_cnt;
  logic [SW-1:0]        samp_cnt;
  logic [2:0]           bit_cnt;
  logic [7:0]           shreg;
  logic                 perr, ferr;

  // frame configuration, frozen for the duration of a frame
  logic [DIV_WIDTH-1:0] div_l;
  logic                 ds_l, pen_l, sb_l;
  logic [1:0]           pm_l;

  logic tick, samp_pt, bit_val, par_exp, fin;

  assign tick    = (state != IDLE) && (tick_cnt == div_l);
  assign samp_pt = tick && (samp_cnt == ((state == START) ? HALF_M1 : FULL_M1));
  assign fin     = samp_pt && ((state == STOP2) || ((state == STOP1) && !sb_l));

`ifdef UART_RX_MAJORITY_VOTE_EN
  // rx_s captured on the two ticks preceding the current one
  logic [1:0] hist;
  assign bit_val = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);

  // tick-rate history of the line; zeroed at start since the line just fell
  always_ff @(posedge clk) begin
    if (rst)                           hist <= 2'b11;
    else if (state == IDLE && armed && !rx_s) hist <= 2'b00;
    else if (tick)                     hist <= {hist[0], rx_s};
  end
`else
  assign bit_val = rx_s;
`endif

  // expected parity bit over the received data bits (bit7 is 0 in 7-bit mode)
  always_comb begin
    par_exp = 1'b0;
    case (pm_l)
      2'b11:   par_exp = ~^shreg;
      2'b10:   par_exp = ^shreg;
      2'b01:   par_exp = 1'b1;
      default: par_exp = 1'b0;
    endcase
  end

  // synchronizer, tick generator, framing FSM and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1; rx_s <= 1'b1;
      state <= IDLE; armed <= 1'b0; busy <= 1'b0;
      tick_cnt <= '0; samp_cnt <= '0; bit_cnt <= '0;
      shreg <= '0; perr <= 1'b0; ferr <= 1'b0;
      div_l <= '0; ds_l <= 1'b0; pen_l <= 1'b0; pm_l <= 2'b00; sb_l <= 1'b0;
      data <= '0; valid <= 1'b0; parity_error <= 1'b0; frame_error <= 1'b0;
    end else begin
      rx_m  <= rx;
      rx_s  <= rx_m;
      valid <= 1'b0;

      if (state == IDLE || tick) tick_cnt <= '0;
      else                       tick_cnt <= tick_cnt + 1'b1;

      if (tick) samp_cnt <= samp_pt ? '0 : samp_cnt + 1'b1;

      case (state)
        IDLE: begin
          samp_cnt <= '0;
          bit_cnt  <= '0;
          if (rx_s) armed <= 1'b1;
          if (armed && !rx_s) begin
            state <= START; busy <= 1'b1; armed <= 1'b0;
            div_l <= clk_div; ds_l <= data_size; pen_l <= parity_en;
            pm_l <= parity_mode; sb_l <= stop_bit_size;
          end
        end
        START: if (samp_pt) begin
          if (bit_val) begin
            state <= IDLE; busy <= 1'b0;
          end else begin
            state <= DATA; bit_cnt <= '0;
            shreg <= '0; perr <= 1'b0; ferr <= 1'b0;
          end
        end
        DATA: if (samp_pt) begin
          shreg[bit_cnt] <= bit_val;
          if (bit_cnt == (ds_l ? 3'd7 : 3'd6)) state <= pen_l ? PARITY : STOP1;
          else                                 bit_cnt <= bit_cnt + 1'b1;
        end
        PARITY: if (samp_pt) begin
          perr  <= (bit_val != par_exp);
          state <= STOP1;
        end
        STOP1: if (samp_pt) begin
          if (!bit_val) ferr <= 1'b1;
          if (sb_l) state <= STOP2;
        end
        default: ;
      endcase

      // finish at the mid-stop sample so the next start edge is never missed
      if (fin) begin
        state        <= IDLE;
        busy         <= 1'b0;
        valid        <= 1'b1;
        data         <= shreg;
        parity_error <= perr;
        frame_error  <= ferr | ~bit_val;
      end
    end
  end

endmodule
